alu_control_unit: RTL and testbench
===================================

ALU_CONTROL_UNIT -- requirements
Module: alu_control_unit

Interface
REQ-001 Clock  input  1  system clock; all state changes on rising edge.
REQ-002 clear  input  1  reset, synchronous, active-high.
REQ-003 Run  input  1  start/continue execution; sampled in IDLE only.
REQ-004 Mem_ready  input  1  memory read data valid on Mdatain this cycle.
REQ-005 IR  input  32  datapath IR contents; [31:27] opcode, [26:23] ra, [22:19] rb, [18:15] rc.
REQ-006 PCout, MARin, Zin, PCin, IncPC, Read, MDRin, MDRout, IRin, Yin, Zlowout, Zhighout, LOin, HIin  output  1 each  datapath control strobes, active-high.
REQ-007 Rin_sel  output  16  one-hot general-register load enables (bit n = Rn in).
REQ-008 Rout_sel  output  16  one-hot general-register bus-drive enables (bit n = Rn out).
REQ-009 ALU_op  output  5  ALU operation code; 5'b00000 = no-op.
REQ-010 Busy  output  1  high in every state except IDLE and HALT.
REQ-011 Halted  output  1  high in HALT.
REQ-012 Illegal  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-013 States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; one state register; all outputs decoded from present state and IR only (Moore, no input-to-output paths except via IR).
REQ-014 IDLE: all strobes 0; Run=1 -> T0, else stay.
REQ-015 T0: PCout=1, MARin=1, Zin=1; -> T1.
REQ-016 T1: Zlowout=1, PCin=1, IncPC=1, Read=1, MDRin=1; stay while Mem_ready=0; -> T2 on Mem_ready=1; PCin/IncPC/Zin-derived PC update effective only on exit cycle (PCin, IncPC asserted only when Mem_ready=1).
REQ-017 T2: MDRout=1, IRin=1; -> T3; IR valid from T3 onward.
REQ-018 Supported opcodes: add 00011, sub 00100, and 01010, or 01011, mul 01111, halt 11011.
REQ-019 T3 (ALU ops): Rout_sel=onehot(rb), Yin=1; -> T4.
REQ-020 T4: Rout_sel=onehot(rc), Zin=1, ALU_op=IR[31:27]; -> T5.
REQ-021 T5 non-mul: Zlowout=1, Rin_sel=onehot(ra); -> T0.
REQ-022 T5 mul: Zlowout=1, LOin=1, Rin_sel=0; -> T6.
REQ-023 T6 (mul only): Zhighout=1, HIin=1; -> T0.
REQ-024 T3 with halt opcode: no strobes; -> HALT.
REQ-025 T3 with unsupported opcode: Illegal=1 for that cycle, no other strobes; -> T0 (instruction skipped).
REQ-026 HALT: all strobes 0, Halted=1; leave only via clear.
REQ-027 ALU_op=0 and Rin_sel=Rout_sel=0 in all states not listed above; at most one Rout_sel bit and at most one bus driver (PCout, MDRout, Zlowout, Zhighout, Rout_sel) active per cycle.
REQ-028 ra=0 write: Rin_sel bit 0 asserted as for any register (R0 handling belongs to datapath).
REQ-029 Run is ignored outside IDLE; execution is continuous once started.
REQ-030 Latency: non-mul instruction = 6 cycles with Mem_ready=1 in first T1 cycle; mul = 7; each stalled T1 cycle adds 1.

Reset
REQ-031 clear=1 at a rising edge -> state IDLE next cycle from any state, including mid-T1 stall and HALT; clear overrides Run and Mem_ready.
REQ-032 After reset all outputs 0 (Rin_sel, Rout_sel, ALU_op = 0; Busy=Halted=Illegal=0).
REQ-033 No other internal state survives reset.

Verification
REQ-034 clear, Run=1, Mem_ready=1, IR=32'h50918000 (and R1,R2,R3) -> T0..T5 in 6 cycles; T3 Rout_sel=16'h0004+Yin, T4 Rout_sel=16'h0008+Zin+ALU_op=01010, T5 Rin_sel=16'h0002+Zlowout; then T0.
REQ-035 Mem_ready=0 for 3 cycles in T1 -> T1 held 4 cycles, PCin/IncPC high only in last; then T2 MDRout+IRin.
REQ-036 IR=32'h78918000 (mul R1,R2,R3) -> T5 Zlowout+LOin with Rin_sel=0, T6 Zhighout+HIin, total 7 cycles.
REQ-037 IR opcode 11011 -> HALT after T3, Halted=1, Busy=0, stays with Run toggling; clear -> IDLE.
REQ-038 IR opcode 11111 -> Illegal one-cycle pulse at T3, no Rin_sel, next state T0.
REQ-039 clear asserted during T4 -> IDLE next cycle, all outputs 0; Run=1 restarts at T0.

Source files
------------

// File: rtl/alu_control_unit.sv
// Hardwired control unit for a bus-based datapath: fetch (T0-T2) followed by
// a register-register ALU sequence (T3-T5, plus T6 for the HI half of mul).
// Outputs are a pure decode of the present state and IR. PCin/IncPC in T1 are
// the exception: they are qualified by Mem_ready, so the PC advances only on
// the cycle that leaves T1.
module alu_control_unit (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Run,
  input  logic        Mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        IncPC,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        LOin,
  output logic        HIin,
  output logic [15:0] Rin_sel,
  output logic [15:0] Rout_sel,
  output logic [4:0]  ALU_op,
  output logic        Busy,
  output logic        Halted,
  output logic        Illegal
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t state_q, state_d;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic [15:0] ra_hot, rb_hot, rc_hot;
  logic        is_alu, is_mul, is_halt;
  logic        unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign ra_hot = 16'h0001 << ra;
  assign rb_hot = 16'h0001 << rb;
  assign rc_hot = 16'h0001 << rc;

  // Opcode classification
  always_comb begin
    is_alu  = 1'b0;
    is_mul  = (opcode == OP_MUL);
    is_halt = (opcode == OP_HALT);
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL: is_alu = 1'b1;
      default:                               is_alu = 1'b0;
    endcase
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (Run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (Mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (is_alu)       state_d = S_T4;
        else if (is_halt) state_d = S_HALT;
        else              state_d = S_T0;
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = is_mul ? S_T6 : S_T0;
      S_T6:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous clear
  always_ff @(posedge Clock) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Output decode from present state and IR. IR is only loaded at the end of
  // T2, so these cannot be precomputed into registers a cycle early.
  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    Rin_sel  = '0;
    Rout_sel = '0;
    ALU_op   = '0;
    Busy     = 1'b1;
    Halted   = 1'b0;
    Illegal  = 1'b0;
    case (state_q)
      S_IDLE: Busy = 1'b0;
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = Mem_ready;
        IncPC   = Mem_ready;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (is_alu) begin
          Rout_sel = rb_hot;
          Yin      = 1'b1;
        end else if (!is_halt) begin
          Illegal = 1'b1;
        end
      end
      S_T4: begin
        Rout_sel = rc_hot;
        Zin      = 1'b1;
        ALU_op   = opcode;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_mul) LOin    = 1'b1;
        else        Rin_sel = ra_hot;
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      S_HALT: begin
        Busy   = 1'b0;
        Halted = 1'b1;
      end
      default: Busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: directed scenarios with literal expectations,
// then randomized Run/Mem_ready/clear/IR against an instruction-phase model.
module tb_alu_control_unit;

  logic        Clock = 1'b0;
  logic        clear, Run, Mem_ready;
  logic [31:0] IR;
  logic        PCout, MARin, Zin, PCin, IncPC, Read, MDRin, MDRout, IRin, Yin;
  logic        Zlowout, Zhighout, LOin, HIin, Busy, Halted, Illegal;
  logic [15:0] Rin_sel, Rout_sel;
  logic [4:0]  ALU_op;

  int checks = 0;
  int failures = 0;

  alu_control_unit dut (
    .Clock(Clock), .clear(clear), .Run(Run), .Mem_ready(Mem_ready), .IR(IR),
    .PCout(PCout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .IncPC(IncPC),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin),
    .Rin_sel(Rin_sel), .Rout_sel(Rout_sel), .ALU_op(ALU_op),
    .Busy(Busy), .Halted(Halted), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  // Model: mode 0 idle, 1 running, 2 halted; pos = cycle index within an
  // instruction, not counting T1 stall cycles.
  int m_mode = 0;
  int m_pos = 0;
  bit m_valid = 1'b0;

  function automatic bit is_alu_op(logic [4:0] op);
    return op == 5'd3 || op == 5'd4 || op == 5'd10 || op == 5'd11 || op == 5'd15;
  endfunction

  function automatic logic [53:0] expected(int mode, int pos, logic [31:0] ir, logic mr);
    logic [4:0] op;
    logic pco, mar, zi, pci, inc, rd, mdi, mdo, iri, yi, zlo, zho, loi, hii, bsy, hlt, ill;
    logic [15:0] rin, rout;
    logic [4:0] aop;
    op = ir[31:27];
    {pco, mar, zi, pci, inc, rd, mdi, mdo, iri, yi, zlo, zho, loi, hii, bsy, hlt, ill} = '0;
    rin = '0; rout = '0; aop = '0;
    bsy = (mode == 1);
    hlt = (mode == 2);
    if (mode == 1) begin
      if (pos == 0) begin pco = 1; mar = 1; zi = 1; end
      if (pos == 1) begin zlo = 1; rd = 1; mdi = 1; pci = mr; inc = mr; end
      if (pos == 2) begin mdo = 1; iri = 1; end
      if (pos == 3) begin
        if (is_alu_op(op)) begin rout = 16'd1 << ir[22:19]; yi = 1; end
        else if (op != 5'd27) ill = 1;
      end
      if (pos == 4) begin rout = 16'd1 << ir[18:15]; zi = 1; aop = op; end
      if (pos == 5) begin
        zlo = 1;
        if (op == 5'd15) loi = 1; else rin = 16'd1 << ir[26:23];
      end
      if (pos == 6) begin zho = 1; hii = 1; end
    end
    return {pco, mar, zi, pci, inc, rd, mdi, mdo, iri, yi, zlo, zho, loi, hii,
            rin, rout, aop, bsy, hlt, ill};
  endfunction

  function automatic logic [53:0] actual();
    return {PCout, MARin, Zin, PCin, IncPC, Read, MDRin, MDRout, IRin, Yin,
            Zlowout, Zhighout, LOin, HIin, Rin_sel, Rout_sel, ALU_op, Busy, Halted, Illegal};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle at negedge, advance the model at posedge.
  initial begin
    forever begin
      @(negedge Clock);
      if (m_valid) chk("model_outputs", 64'(actual()), 64'(expected(m_mode, m_pos, IR, Mem_ready)));
      @(posedge Clock);
      if (clear) begin
        m_mode = 0; m_pos = 0; m_valid = 1'b1;
      end else if (m_mode == 0) begin
        if (Run) begin m_mode = 1; m_pos = 0; end
      end else if (m_mode == 1) begin
        case (m_pos)
          1: if (Mem_ready) m_pos = 2;
          3: begin
            if (IR[31:27] == 5'd27) m_mode = 2;
            else if (is_alu_op(IR[31:27])) m_pos = 4;
            else m_pos = 0;
          end
          5: m_pos = (IR[31:27] == 5'd15) ? 6 : 0;
          6: m_pos = 0;
          default: m_pos = m_pos + 1;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  int hc;
  int r;
  logic [4:0] ops [5] = '{5'd3, 5'd4, 5'd10, 5'd11, 5'd15};

  initial begin
    clear = 1; Run = 0; Mem_ready = 0; IR = '0;
    tick();
    clear = 0; Run = 1; Mem_ready = 1; IR = 32'h50918000;
    @(negedge Clock);
    chk("reset_outputs", 64'(actual()), 64'd0);
    tick(); Run = 0;
    @(negedge Clock); chk("and_t0", {PCout, MARin, Zin}, 3'b111);
    tick(); @(negedge Clock); chk("and_t1", {PCin, IncPC, Read, MDRin, Zlowout}, 5'b11111);
    tick(); @(negedge Clock); chk("and_t2", {MDRout, IRin}, 2'b11);
    tick(); @(negedge Clock); chk("and_t3", {Rout_sel, Yin}, {16'h0004, 1'b1});
    tick(); @(negedge Clock); chk("and_t4", {Rout_sel, Zin, ALU_op}, {16'h0008, 1'b1, 5'b01010});
    tick(); @(negedge Clock); chk("and_t5", {Rin_sel, Zlowout}, {16'h0002, 1'b1});
    tick(); Mem_ready = 0;
    @(negedge Clock); chk("and_next_t0", PCout, 1'b1);
    // three stalled T1 cycles
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge Clock); chk("stall_t1", {Read, PCin, IncPC}, 3'b100);
    end
    tick(); Mem_ready = 1;
    @(negedge Clock); chk("stall_exit", {Read, PCin, IncPC}, 3'b111);
    tick(); IR = 32'h78918000;
    @(negedge Clock); chk("stall_t2", {MDRout, IRin}, 2'b11);
    tick(); tick();
    @(negedge Clock); chk("mul_t4", ALU_op, 5'b01111);
    tick(); @(negedge Clock); chk("mul_t5", {Zlowout, LOin, Rin_sel}, {2'b11, 16'h0000});
    tick(); @(negedge Clock); chk("mul_t6", {Zhighout, HIin}, 2'b11);
    tick(); IR = 32'hD8000000;
    @(negedge Clock); chk("mul_next_t0", PCout, 1'b1);
    tick(); tick(); tick();
    @(negedge Clock); chk("halt_t3", 64'(actual()), 64'd4);
    for (int i = 0; i < 3; i++) begin
      tick(); Run = ~Run;
      @(negedge Clock); chk("halt_state", {Halted, Busy}, 2'b10);
    end
    clear = 1;
    tick(); clear = 0; Run = 1; IR = 32'hF8000000;
    @(negedge Clock); chk("halt_clear", 64'(actual()), 64'd0);
    tick(); Run = 0; tick(); tick(); tick();
    @(negedge Clock); chk("illegal_t3", {Illegal, Rin_sel, Rout_sel, Yin}, {1'b1, 33'd0});
    tick(); IR = 32'h18918000;
    @(negedge Clock); chk("illegal_next", {Illegal, PCout}, 2'b01);
    tick(); tick(); tick(); tick();
    @(negedge Clock); chk("add_t4", ALU_op, 5'b00011);
    clear = 1;
    tick(); clear = 0; Run = 1;
    @(negedge Clock); chk("clear_t4", 64'(actual()), 64'd0);
    tick(); Run = 0;
    @(negedge Clock); chk("restart_t0", PCout, 1'b1);

    hc = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      hc = (m_mode == 2) ? hc + 1 : 0;
      clear = ($urandom % 60 == 0) || (hc > 3);
      Run = 1'($urandom % 2);
      Mem_ready = ($urandom % 4) != 0;
      if (m_mode != 1 || m_pos == 0) begin
        r = $urandom % 16;
        IR = $urandom;
        if (r < 11)       IR[31:27] = ops[$urandom % 5];
        else if (r == 11) IR[31:27] = 5'd27;
      end
    end
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
